scan_scheduler: RTL

//   Multi-scan controller for the pulse/acquisition datapath. On one start command it

---
 rtl/scan_scheduler_if.sv | 30 +++
 rtl/scan_scheduler.sv | 188 ++++++++++++++++++
 2 files changed

// File: rtl/scan_scheduler_if.sv
// Host/pulse-programmer signal bundle for the multi-scan scheduler.
// The slave modport is the scheduler's view; master is the host/programmer side.
interface scan_scheduler_if #(
    parameter int PH_ENTRIES = 4
);
    logic                      start;
    logic                      abort;
    logic [15:0]               num_scans;
    logic [31:0]               rep_delay;
    logic [5*PH_ENTRIES-1:0]   phase_table;
    logic [2:0]                phase_len;
    logic                      seq_done;
    logic                      seq_trig;
    logic [4:0]                tx_phase;
    logic [15:0]               scan_idx;
    logic                      busy;
    logic                      done;
    logic                      aborted;
    logic                      timeout_err;

    modport slave (
        input  start, abort, num_scans, rep_delay, phase_table, phase_len, seq_done,
        output seq_trig, tx_phase, scan_idx, busy, done, aborted, timeout_err
    );

    modport master (
        output start, abort, num_scans, rep_delay, phase_table, phase_len, seq_done,
        input  seq_trig, tx_phase, scan_idx, busy, done, aborted, timeout_err
    );
endinterface

// File: rtl/scan_scheduler.sv
// Multi-scan controller: fires the pulse programmer num_scans times with a repetition
// delay, cycles tx phase through a table and guards every shot with a watchdog.
module scan_scheduler #(
    parameter int PH_ENTRIES  = 4,
    parameter int WDOG_CYCLES = 2**24
) (
    input  logic              clk,
    input  logic              rst,
    scan_scheduler_if.slave   bus
);
    localparam int          PH_W     = 5 * PH_ENTRIES;
    localparam int          PTR_W    = (PH_ENTRIES > 1) ? $clog2(PH_ENTRIES) : 1;
    localparam logic [2:0]  PH_MAX   = 3'(PH_ENTRIES);
    localparam logic [31:0] WDOG_LIM = 32'(WDOG_CYCLES - 1);

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_FIRE   = 3'd1,
        ST_WAIT   = 3'd2,
        ST_DELAY  = 3'd3,
        ST_FINISH = 3'd4
    } state_t;

    function automatic logic [4:0] ph_sel(input logic [PH_W-1:0] tbl, input logic [PTR_W-1:0] idx);
        logic [4:0] r;
        r = 5'd0;
        for (int i = 0; i < PH_ENTRIES; i++) begin
            if (idx == PTR_W'(i)) begin
                r = tbl[i*5 +: 5];
            end
        end
        return r;
    endfunction

    state_t            state_r, state_next_s;
    logic [15:0]       nscan_r, scan_idx_r;
    logic [31:0]       rep_r, dly_r, wdog_r;
    logic [PH_W-1:0]   table_r;
    logic [PTR_W-1:0]  len_m1_r, len_m1_s, ptr_r, ptr_next_s;
    logic [4:0]        tx_phase_r;
    logic              seq_trig_r, busy_r, done_r, aborted_r, tout_r;
    logic              accept_s, zero_s, shot_s, last_s, tout_s, abort_s;

    assign last_s     = (scan_idx_r + 16'd1) == nscan_r;
    assign ptr_next_s = (ptr_r == len_m1_r) ? {PTR_W{1'b0}} : ptr_r + PTR_W'(1);

    // Clamp the requested phase-cycle length to 1..PH_ENTRIES, stored as length-1.
    always_comb begin
        len_m1_s = {PTR_W{1'b0}};
        if (bus.phase_len == 3'd0) begin
            len_m1_s = {PTR_W{1'b0}};
        end else if (bus.phase_len > PH_MAX) begin
            len_m1_s = PTR_W'(PH_ENTRIES - 1);
        end else begin
            len_m1_s = PTR_W'(bus.phase_len - 3'd1);
        end
    end

    // State register.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r <= ST_IDLE;
        end else begin
            state_r <= state_next_s;
        end
    end

    // Next-state decode and per-cycle control strobes; abort overrides everything.
    always_comb begin
        state_next_s = state_r;
        accept_s     = 1'b0;
        zero_s       = 1'b0;
        shot_s       = 1'b0;
        tout_s       = 1'b0;
        abort_s      = 1'b0;
        case (state_r)
            ST_IDLE: begin
                if (bus.start && (bus.num_scans == 16'd0)) begin
                    zero_s = 1'b1;
                end else if (bus.start) begin
                    accept_s     = 1'b1;
                    state_next_s = ST_FIRE;
                end else begin
                    state_next_s = ST_IDLE;
                end
            end
            ST_FIRE: state_next_s = ST_WAIT;
            ST_WAIT: begin
                if (bus.seq_done) begin
                    shot_s = 1'b1;
                    if (last_s) begin
                        state_next_s = ST_FINISH;
                    end else if (rep_r == 32'd0) begin
                        state_next_s = ST_FIRE;
                    end else begin
                        state_next_s = ST_DELAY;
                    end
                end else if (wdog_r == WDOG_LIM) begin
                    tout_s       = 1'b1;
                    state_next_s = ST_IDLE;
                end else begin
                    state_next_s = ST_WAIT;
                end
            end
            ST_DELAY: begin
                if (dly_r == 32'd0) begin
                    state_next_s = ST_FIRE;
                end else begin
                    state_next_s = ST_DELAY;
                end
            end
            ST_FINISH: state_next_s = ST_IDLE;
            default:   state_next_s = ST_IDLE;
        endcase
        if (bus.abort && (state_r != ST_IDLE)) begin
            abort_s      = 1'b1;
            shot_s       = 1'b0;
            tout_s       = 1'b0;
            state_next_s = ST_IDLE;
        end else begin
            abort_s      = 1'b0;
        end
    end

    // Datapath: latched config, counters, phase pointer and registered outputs.
    always_ff @(posedge clk) begin
        if (rst) begin
            nscan_r    <= 16'd0;
            scan_idx_r <= 16'd0;
            rep_r      <= 32'd0;
            dly_r      <= 32'd0;
            wdog_r     <= 32'd0;
            table_r    <= {PH_W{1'b0}};
            len_m1_r   <= {PTR_W{1'b0}};
            ptr_r      <= {PTR_W{1'b0}};
            tx_phase_r <= 5'd0;
            seq_trig_r <= 1'b0;
            busy_r     <= 1'b0;
            done_r     <= 1'b0;
            aborted_r  <= 1'b0;
            tout_r     <= 1'b0;
        end else begin
            seq_trig_r <= (state_next_s == ST_FIRE);
            busy_r     <= (state_next_s != ST_IDLE);
            done_r     <= (state_next_s == ST_FINISH) || zero_s;
            aborted_r  <= abort_s;
            if (accept_s || zero_s) begin
                tout_r <= 1'b0;
            end else if (tout_s) begin
                tout_r <= 1'b1;
            end
            if (accept_s) begin
                nscan_r    <= bus.num_scans;
                rep_r      <= bus.rep_delay;
                table_r    <= bus.phase_table;
                len_m1_r   <= len_m1_s;
                ptr_r      <= {PTR_W{1'b0}};
                scan_idx_r <= 16'd0;
                tx_phase_r <= bus.phase_table[4:0];
            end
            if (state_r == ST_FIRE) begin
                wdog_r <= 32'd0;
            end else if (state_r == ST_WAIT) begin
                wdog_r <= wdog_r + 32'd1;
            end
            if (shot_s) begin
                scan_idx_r <= scan_idx_r + 16'd1;
                if (!last_s) begin
                    ptr_r      <= ptr_next_s;
                    tx_phase_r <= ph_sel(table_r, ptr_next_s);
                    if (rep_r != 32'd0) begin
                        dly_r <= rep_r - 32'd1;
                    end
                end
            end else if ((state_r == ST_DELAY) && (dly_r != 32'd0)) begin
                dly_r <= dly_r - 32'd1;
            end
        end
    end

    assign bus.seq_trig    = seq_trig_r;
    assign bus.tx_phase    = tx_phase_r;
    assign bus.scan_idx    = scan_idx_r;
    assign bus.busy        = busy_r;
    assign bus.done        = done_r;
    assign bus.aborted     = aborted_r;
    assign bus.timeout_err = tout_r;
endmodule
